// File: rtl/vend_pkg.sv
// Shared types and constants for the vending payment path.
package vend_pkg;

  typedef enum logic [1:0] {
    StCollect,
    StVend,
    StPayout,
    StRefund
  } state_e;

  localparam logic [1:0] ST_COLLECT = 2'b00;
  localparam logic [1:0] ST_VEND    = 2'b01;
  localparam logic [1:0] ST_CHANGE  = 2'b11;
  localparam logic [1:0] ST_REFUND  = 2'b10;

  localparam int unsigned DEF_CREDIT_W    = 8;
  localparam int unsigned DEF_PRICE       = 25;
  localparam int unsigned DEF_COIN0_VAL   = 5;
  localparam int unsigned DEF_COIN1_VAL   = 10;
  localparam int unsigned DEF_CHANGE_UNIT = 5;

endpackage

// File: rtl/vend_hold_timer.sv
// Reloadable down-counter; expire marks the last of N cycles after a load of N.
module vend_hold_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expire = (r_count == WIDTH'(1));

endmodule

// File: rtl/vend_sequencer.sv
// Payment sequencer: collects coin credit, runs a timed dispense, then pays change or refunds.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W    = DEF_CREDIT_W,
  parameter int unsigned PRICE       = DEF_PRICE,
  parameter int unsigned COIN0_VAL   = DEF_COIN0_VAL,
  parameter int unsigned COIN1_VAL   = DEF_COIN1_VAL,
  parameter int unsigned CHANGE_UNIT = DEF_CHANGE_UNIT,
  parameter int unsigned HOLD_CYCLES = 100_000_000,
  parameter int unsigned GAP_CYCLES  = 25_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          i_coin,
  input  logic                i_cancel,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_dispense,
  output logic                o_change_pulse,
  output logic [CREDIT_W-1:0] o_change_left,
  output logic                o_coin_reject,
  output logic [1:0]          o_status,
  output logic                o_busy
);

  localparam int unsigned MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TIMER_W = $clog2(MAX_CYC + 1);

  localparam logic [CREDIT_W-1:0] L_PRICE = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] L_UNIT  = CREDIT_W'(CHANGE_UNIT);
  localparam logic [CREDIT_W:0]   L_C0    = (CREDIT_W + 1)'(COIN0_VAL);
  localparam logic [CREDIT_W:0]   L_C1    = (CREDIT_W + 1)'(COIN1_VAL);
  localparam logic [TIMER_W-1:0]  L_HOLD  = TIMER_W'(HOLD_CYCLES);
  localparam logic [TIMER_W-1:0]  L_GAP   = TIMER_W'(GAP_CYCLES);

  state_e              r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic [CREDIT_W-1:0] r_change_left, w_change_nxt;
  logic                r_dispense, r_change_pulse, r_coin_reject, r_busy;
  logic                w_pulse_nxt, w_reject_nxt;
  logic [1:0]          r_status, w_status_nxt;
  logic [CREDIT_W:0]   w_add, w_sum;
  logic                w_tmr_load, w_expire;
  logic [TIMER_W-1:0]  w_tmr_val;

  vend_hold_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expire   (w_expire)
  );

  assign w_add = (i_coin[0] ? L_C0 : '0) + (i_coin[1] ? L_C1 : '0);
  assign w_sum = {1'b0, r_credit} + w_add;

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_change_nxt = r_change_left;
    w_pulse_nxt  = 1'b0;
    w_reject_nxt = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    w_status_nxt = ST_COLLECT;

    unique case (r_state)
      StCollect: begin
        if (r_credit >= L_PRICE) begin
          w_state_nxt  = StVend;
          w_change_nxt = r_credit - L_PRICE;
          w_credit_nxt = '0;
          w_tmr_load   = 1'b1;
          w_tmr_val    = L_HOLD;
          w_reject_nxt = |i_coin;
        end else if (i_cancel && (r_credit != '0)) begin
          w_state_nxt  = StRefund;
          w_change_nxt = r_credit;
          w_credit_nxt = '0;
          w_tmr_load   = 1'b1;
          w_tmr_val    = L_GAP;
          w_pulse_nxt  = 1'b1;
          w_reject_nxt = |i_coin;
        end else if (w_sum[CREDIT_W]) begin
          w_reject_nxt = 1'b1;
        end else begin
          w_credit_nxt = w_sum[CREDIT_W-1:0];
        end
      end
      StVend: begin
        w_reject_nxt = |i_coin;
        if (w_expire) begin
          if (r_change_left != '0) begin
            w_state_nxt = StPayout;
            w_pulse_nxt = 1'b1;
            w_tmr_load  = 1'b1;
            w_tmr_val   = L_GAP;
          end else begin
            w_state_nxt = StCollect;
          end
        end
      end
      StPayout, StRefund: begin
        w_reject_nxt = |i_coin;
        // The unit leaves change_left at the end of its pulse cycle.
        if (r_change_pulse) begin
          if (r_change_left <= L_UNIT) begin
            w_change_nxt = '0;
            w_state_nxt  = StCollect;
          end else begin
            w_change_nxt = r_change_left - L_UNIT;
          end
        end
        if (w_expire && (w_state_nxt != StCollect)) begin
          w_pulse_nxt = 1'b1;
          w_tmr_load  = 1'b1;
          w_tmr_val   = L_GAP;
        end
      end
    endcase

    unique case (w_state_nxt)
      StCollect: w_status_nxt = ST_COLLECT;
      StVend:    w_status_nxt = (w_change_nxt == '0) ? ST_VEND : ST_CHANGE;
      StPayout:  w_status_nxt = ST_CHANGE;
      StRefund:  w_status_nxt = ST_REFUND;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StCollect;
      r_credit       <= '0;
      r_change_left  <= '0;
      r_dispense     <= 1'b0;
      r_change_pulse <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_status       <= ST_COLLECT;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_credit       <= w_credit_nxt;
      r_change_left  <= w_change_nxt;
      r_dispense     <= (w_state_nxt == StVend);
      r_change_pulse <= w_pulse_nxt;
      r_coin_reject  <= w_reject_nxt;
      r_status       <= w_status_nxt;
      r_busy         <= (w_state_nxt != StCollect);
    end
  end

  assign o_credit       = r_credit;
  assign o_dispense     = r_dispense;
  assign o_change_pulse = r_change_pulse;
  assign o_change_left  = r_change_left;
  assign o_coin_reject  = r_coin_reject;
  assign o_status       = r_status;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: directed vector table, hand sequences, random run against a model.
module tb_vend_sequencer;

  localparam int HOLD = 8;
  localparam int GAP  = 4;
  localparam int PRICE = 25;
  localparam int C0 = 5;
  localparam int C1 = 10;
  localparam int UNIT = 5;
  localparam int CMAX = 255;
  localparam int PH_COLLECT = 0, PH_VEND = 1, PH_PAY = 2, PH_REFUND = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] i_coin = 2'b00;
  logic       i_cancel = 1'b0;
  logic [7:0] o_credit, o_change_left;
  logic       o_dispense, o_change_pulse, o_coin_reject, o_busy;
  logic [1:0] o_status;

  always #5 clk = ~clk;

  vend_sequencer #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_coin         (i_coin),
    .i_cancel       (i_cancel),
    .o_credit       (o_credit),
    .o_dispense     (o_dispense),
    .o_change_pulse (o_change_pulse),
    .o_change_left  (o_change_left),
    .o_coin_reject  (o_coin_reject),
    .o_status       (o_status),
    .o_busy         (o_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase plus cycles elapsed in it; pulses fall on multiples of GAP.
  int   m_phase, m_t, m_credit, m_owed;
  logic m_rej;

  typedef struct {
    logic [1:0] coin;
    logic       cancel;
    int         credit;
    int         disp;
    int         pulse;
    int         cl;
    int         rej;
    int         st;
    int         busy;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] c, input logic x, input int credit, input int disp,
                         input int pulse, input int cl, input int rej, input int st,
                         input int busy);
    vec_t v;
    v.coin = c; v.cancel = x; v.credit = credit; v.disp = disp; v.pulse = pulse;
    v.cl = cl; v.rej = rej; v.st = st; v.busy = busy;
    tbl.push_back(v);
  endtask

  task automatic model_reset();
    m_phase = PH_COLLECT; m_t = 0; m_credit = 0; m_owed = 0; m_rej = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] c, input logic x);
    int add;
    add = (c[0] ? C0 : 0) + (c[1] ? C1 : 0);
    m_rej = 1'b0;
    case (m_phase)
      PH_COLLECT: begin
        if (m_credit >= PRICE) begin
          m_phase = PH_VEND; m_t = 0; m_owed = m_credit - PRICE; m_credit = 0;
          m_rej = (add != 0);
        end else if (x && m_credit > 0) begin
          m_phase = PH_REFUND; m_t = 0; m_owed = m_credit; m_credit = 0;
          m_rej = (add != 0);
        end else if (m_credit + add > CMAX) begin
          m_rej = 1'b1;
        end else begin
          m_credit = m_credit + add;
        end
      end
      PH_VEND: begin
        m_rej = (add != 0);
        m_t++;
        if (m_t == HOLD) begin
          m_t = 0;
          m_phase = (m_owed > 0) ? PH_PAY : PH_COLLECT;
        end
      end
      default: begin
        m_rej = (add != 0);
        if (m_t % GAP == 0) begin
          m_owed = m_owed - UNIT;
          if (m_owed <= 0) begin
            m_owed = 0;
            m_phase = PH_COLLECT;
          end
        end
        m_t++;
      end
    endcase
  endtask

  task automatic cmp_model(input int n);
    int st;
    case (m_phase)
      PH_COLLECT: st = 0;
      PH_VEND:    st = (m_owed == 0) ? 1 : 3;
      PH_PAY:     st = 3;
      default:    st = 2;
    endcase
    chk($sformatf("rnd[%0d] credit", n), 32'(o_credit), m_credit);
    chk($sformatf("rnd[%0d] dispense", n), 32'(o_dispense), 32'(m_phase == PH_VEND));
    chk($sformatf("rnd[%0d] pulse", n), 32'(o_change_pulse),
        32'(m_phase >= PH_PAY && (m_t % GAP == 0)));
    chk($sformatf("rnd[%0d] change_left", n), 32'(o_change_left), m_owed);
    chk($sformatf("rnd[%0d] reject", n), 32'(o_coin_reject), 32'(m_rej));
    chk($sformatf("rnd[%0d] status", n), 32'(o_status), st);
    chk($sformatf("rnd[%0d] busy", n), 32'(o_busy), 32'(m_phase != PH_COLLECT));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [1:0] c, input logic x);
    i_coin = c;
    i_cancel = x;
    @(posedge clk);
    model_step(c, x);
    @(negedge clk);
    i_coin = 2'b00;
    i_cancel = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " credit"}, 32'(o_credit), 0);
    chk({tag, " dispense"}, 32'(o_dispense), 0);
    chk({tag, " pulse"}, 32'(o_change_pulse), 0);
    chk({tag, " change_left"}, 32'(o_change_left), 0);
    chk({tag, " reject"}, 32'(o_coin_reject), 0);
    chk({tag, " status"}, 32'(o_status), 0);
    chk({tag, " busy"}, 32'(o_busy), 0);
  endtask

  initial begin
    int pulses;
    int disp_seen;

    // Exact vend 10+10+5, with a coin refused during the dispense.
    add_vec(2'b10, 1'b0, 10, 0, 0, 0, 0, 0, 0);
    add_vec(2'b10, 1'b0, 20, 0, 0, 0, 0, 0, 0);
    add_vec(2'b01, 1'b0, 25, 0, 0, 0, 0, 0, 0);
    add_vec(2'b00, 1'b0, 0, 1, 0, 0, 0, 1, 1);
    for (int i = 0; i < HOLD - 1; i++)
      add_vec((i == 1) ? 2'b01 : 2'b00, 1'b0, 0, 1, 0, 0, (i == 1) ? 1 : 0, 1, 1);
    add_vec(2'b00, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    // Both coins at credit 20, change of 10 with a cancel during payout.
    add_vec(2'b10, 1'b0, 10, 0, 0, 0, 0, 0, 0);
    add_vec(2'b10, 1'b0, 20, 0, 0, 0, 0, 0, 0);
    add_vec(2'b11, 1'b0, 35, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < HOLD; i++) add_vec(2'b00, 1'b0, 0, 1, 0, 10, 0, 3, 1);
    add_vec(2'b00, 1'b0, 0, 0, 1, 10, 0, 3, 1);
    add_vec(2'b00, 1'b1, 0, 0, 0, 5, 0, 3, 1);
    add_vec(2'b00, 1'b0, 0, 0, 0, 5, 0, 3, 1);
    add_vec(2'b00, 1'b0, 0, 0, 0, 5, 0, 3, 1);
    add_vec(2'b00, 1'b0, 0, 0, 1, 5, 0, 3, 1);
    add_vec(2'b00, 1'b0, 0, 0, 0, 0, 0, 0, 0);

    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].coin, tbl[i].cancel);
      chk($sformatf("tbl[%0d] credit", i), 32'(o_credit), tbl[i].credit);
      chk($sformatf("tbl[%0d] dispense", i), 32'(o_dispense), tbl[i].disp);
      chk($sformatf("tbl[%0d] pulse", i), 32'(o_change_pulse), tbl[i].pulse);
      chk($sformatf("tbl[%0d] change_left", i), 32'(o_change_left), tbl[i].cl);
      chk($sformatf("tbl[%0d] reject", i), 32'(o_coin_reject), tbl[i].rej);
      chk($sformatf("tbl[%0d] status", i), 32'(o_status), tbl[i].st);
      chk($sformatf("tbl[%0d] busy", i), 32'(o_busy), tbl[i].busy);
    end

    // Vend with 5 change.
    repeat (3) step(2'b10, 1'b0);
    chk("chg credit30", 32'(o_credit), 30);
    step(2'b00, 1'b0);
    chk("chg status", 32'(o_status), 3);
    chk("chg change_left", 32'(o_change_left), 5);
    for (int i = 0; i < HOLD - 1; i++) begin
      step(2'b00, 1'b0);
      chk("chg dispense", 32'(o_dispense), 1);
    end
    step(2'b00, 1'b0);
    chk("chg pulse", 32'(o_change_pulse), 1);
    chk("chg dispense off", 32'(o_dispense), 0);
    chk("chg cl5", 32'(o_change_left), 5);
    step(2'b00, 1'b0);
    chk("chg done cl", 32'(o_change_left), 0);
    chk("chg done busy", 32'(o_busy), 0);
    chk("chg done pulse", 32'(o_change_pulse), 0);

    // Refund of 10: pulses 4 cycles apart, no dispense.
    step(2'b10, 1'b0);
    step(2'b00, 1'b1);
    chk("ref status", 32'(o_status), 2);
    chk("ref change_left", 32'(o_change_left), 10);
    chk("ref first pulse", 32'(o_change_pulse), 1);
    chk("ref credit", 32'(o_credit), 0);
    pulses = 1;
    disp_seen = int'(o_dispense);
    for (int k = 1; k <= 5; k++) begin
      step(2'b00, 1'b0);
      if (o_dispense) disp_seen = 1;
      if (o_change_pulse) pulses++;
      chk($sformatf("ref pulse k%0d", k), 32'(o_change_pulse), 32'(k == 4));
    end
    chk("ref pulses", pulses, 2);
    chk("ref no dispense", disp_seen, 0);
    chk("ref end busy", 32'(o_busy), 0);

    // Reset while paying out 5.
    repeat (3) step(2'b10, 1'b0);
    repeat (HOLD + 1) step(2'b00, 1'b0);
    chk("rstmid in payout", 32'(o_status), 3);
    chk("rstmid cl5", 32'(o_change_left), 5);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rstmid");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b11, 1'b0);
    step(2'b10, 1'b0);
    chk("post credit", 32'(o_credit), 25);
    step(2'b00, 1'b0);
    chk("post dispense", 32'(o_dispense), 1);
    chk("post status", 32'(o_status), 1);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [1:0] c;
      logic       x;
      c = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      x = ($urandom_range(0, 7) == 0);
      step(c, x);
      cmp_model(n);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vend_sequencer.md
# vend_sequencer

Sequencer for the vending machine's payment path. It accepts single-cycle coin pulses from the key front-end and accumulates credit. When the credit reaches the price it runs a timed dispense, then pays out any change or a cancel refund as a paced pulse train. It sits between the debounced key inputs and the display and actuator logic, and it is the only owner of the credit register.

## Interface

**Parameters**
- `CREDIT_W`, 8: width of the credit and change registers.
- `PRICE`, 25: vend threshold in credit units.
- `COIN0_VAL`, 5: value of `coin[0]`.
- `COIN1_VAL`, 10: value of `coin[1]`.
- `CHANGE_UNIT`, 5: value returned per `change_pulse`. `PRICE`, `COIN0_VAL` and `COIN1_VAL` are multiples of it.
- `HOLD_CYCLES`, 100_000_000: cycles `dispense` stays high (2 s at 50 MHz).
- `GAP_CYCLES`, 25_000_000: `change_pulse` period. Must be ≥2.

**Ports**
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `coin`, in, 2: single-cycle coin pulses; bit 0 = `COIN0_VAL`, bit 1 = `COIN1_VAL`.
- `cancel`, in, 1: single-cycle refund request.
- `credit`, out, `CREDIT_W`: current accumulated credit.
- `dispense`, out, 1: product release, level.
- `change_pulse`, out, 1: one-cycle pulse per `CHANGE_UNIT` returned.
- `change_left`, out, `CREDIT_W`: change or refund still owed.
- `coin_reject`, out, 1: one-cycle pulse when a coin pulse is refused.
- `status`, out, 2: 00 collect, 01 vend exact, 11 vend with change / change payout, 10 refund.
- `busy`, out, 1: high in every state except COLLECT.

## Operation

**States:** COLLECT, VEND, PAYOUT, REFUND.

**COLLECT**
- Each sampled coin bit adds its value to `credit`. If both bits are high, 15 is added.
- Priority is evaluated on the registered `credit`:
  1. If `credit` ≥ `PRICE`: go to VEND. Load `change_left` = `credit` − `PRICE`, clear `credit`, load the hold timer with `HOLD_CYCLES`. Any coin or cancel in that cycle is refused; a refused coin pulses `coin_reject`.
  2. Else if `cancel` and `credit` > 0: go to REFUND. Load `change_left` = `credit`, clear `credit`, load the gap timer. Any coin in that cycle is rejected.
  3. `cancel` with `credit` = 0 is ignored.
- If adding a coin would exceed 2^`CREDIT_W` − 1, the coin is rejected and `credit` is unchanged.

**VEND**
- `dispense` = 1. `status` = 01 if `change_left` = 0, else 11.
- When the timer expires: go to PAYOUT (timer loaded with `GAP_CYCLES`) if `change_left` > 0, otherwise go to COLLECT.

**PAYOUT / REFUND**
- `change_pulse` fires on the first cycle of the state and then every `GAP_CYCLES` cycles.
- Each pulse subtracts `CHANGE_UNIT` from `change_left`.
- Exit to COLLECT on the cycle after the pulse that brings `change_left` to 0.
- `status` is 11 in PAYOUT and 10 in REFUND.

**In every non-COLLECT state**
- Every coin pulse is rejected (`coin_reject`); `credit` stays 0.
- `cancel` is ignored.

## Timing

- **Reset values:** state COLLECT; `credit` = 0, `change_left` = 0, `dispense` = 0, `change_pulse` = 0, `coin_reject` = 0, `status` = 00, `busy` = 0; timers 0.
- **Reset mid-operation:** everything returns to the reset values immediately. Any owed change is discarded.
- All outputs are registered.
- A coin sampled at edge n appears in `credit` after edge n.
- If that coin reaches `PRICE`, `dispense` rises after edge n+1 and stays high exactly `HOLD_CYCLES` cycles.
- The first `change_pulse` is in the cycle after `dispense` falls, or after edge n+1 for a refund.
- `coin_reject` is asserted in the cycle after the refused coin is sampled.
- Timer expiry is defined as count = 1 on a down-counter loaded with N, giving exactly N cycles.

## Structure

- **Shared package `vend_pkg`:**
  - state enum;
  - `status` encodings (`ST_COLLECT`=2'b00, `ST_VEND`=2'b01, `ST_CHANGE`=2'b11, `ST_REFUND`=2'b10);
  - default price and coin-value constants.
- **Sub-module `vend_hold_timer`:**
  - reloadable down-counter with inputs `load` and `load_val`;
  - outputs `expire`;
  - width sized by `$clog2` of the larger of `HOLD_CYCLES` and `GAP_CYCLES`;
  - shared for the dispense hold and the payout gap.

## Test plan

Bench parameters: `HOLD_CYCLES`=8, `GAP_CYCLES`=4.

1. **Exact vend:** `coin[1]`, `coin[1]`, `coin[0]` on separate cycles → `credit` 10, 20, 25; `dispense` high for 8 cycles; `status` = 01; no `change_pulse`; return to COLLECT with `credit` = 0.
2. **Vend with change:** three `coin[1]` pulses (30) → `dispense` for 8 cycles with `status` = 11, then one `change_pulse` and `change_left` 5→0.
3. **Simultaneous coins:** `coin` = 2'b11 at credit 20 → `credit` = 35, vend, `change_left` = 10, two `change_pulse`s 4 cycles apart.
4. **Refund:** `coin[1]` then `cancel` → `status` = 10, `change_left` = 10, two pulses 4 cycles apart; `dispense` never asserted.
5. **Busy rejection:** `coin[0]` during VEND → `coin_reject` pulse, `credit` stays 0; `cancel` during PAYOUT has no effect.
6. **Reset mid-operation:** `rst_n` low during PAYOUT with `change_left` = 5 → all outputs at reset values immediately; normal vend works after release.
